// File: rtl/cfs_md_pkg.sv
// Shared helpers for the MD realigner.
//   offset_width/size_width/level_width : port widths derived from DATA_WIDTH
//   beat_legal                          : RX beat legality rule
//   sat_inc                             : saturating increment for status counters
package cfs_md_pkg;

  function automatic int offset_width(int data_width);
    return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
  endfunction

  function automatic int size_width(int data_width);
    return $clog2(data_width / 8) + 1;
  endfunction

  // Level spans 0..2*NB inclusive.
  function automatic int level_width(int data_width);
    return $clog2(2 * (data_width / 8)) + 1;
  endfunction

  // A beat must be non-empty, fit in the bus, and sit on a lane boundary
  // that is a multiple of its own size when viewed from the bus origin.
  function automatic logic beat_legal(int nb, int offset, int size);
    if (size == 0) return 1'b0;
    if (offset + size > nb) return 1'b0;
    return ((nb + offset) % size) == 0;
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] value, int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/cfs_md_byte_buffer.sv
// Byte FIFO of 2*NB bytes; byte 0 of the packed store is the oldest byte.
// Each cycle an optional pop of pop_size bytes is applied first, then an
// optional append of push_size bytes taken from lanes push_offset.. of
// push_data. Next-state level and head are exported so the caller can
// register TX outputs that already reflect this cycle's update.
//   clk, reset                 : clock, sync active-high reset (level only)
//   pop, pop_size              : remove pop_size oldest bytes
//   push, push_offset/size/data: append selected lanes at the tail
//   level                      : bytes currently buffered
//   level_nxt, head_nxt        : level and oldest NB bytes after this cycle
module cfs_md_byte_buffer import cfs_md_pkg::*; #(
  parameter  int DATA_WIDTH   = 32,
  localparam int OFFSET_WIDTH = offset_width(DATA_WIDTH),
  localparam int SIZE_WIDTH   = size_width(DATA_WIDTH),
  localparam int LEVEL_WIDTH  = level_width(DATA_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pop,
  input  logic [SIZE_WIDTH-1:0]   pop_size,
  input  logic                    push,
  input  logic [OFFSET_WIDTH-1:0] push_offset,
  input  logic [SIZE_WIDTH-1:0]   push_size,
  input  logic [DATA_WIDTH-1:0]   push_data,
  output logic [LEVEL_WIDTH-1:0]  level,
  output logic [LEVEL_WIDTH-1:0]  level_nxt,
  output logic [DATA_WIDTH-1:0]   head_nxt
);

  localparam int BW = 2 * DATA_WIDTH;

  logic [BW-1:0]          bytes_q;
  logic [BW-1:0]          bytes_nxt;
  logic [BW-1:0]          kept_p0;
  logic [BW-1:0]          rx_bytes_p0;
  logic [BW-1:0]          ins_mask_p0;
  logic [SIZE_WIDTH-1:0]  pop_n_p0;
  logic [LEVEL_WIDTH-1:0] tail_p0;

  // Stage p0: pop (shift out head), then merge appended bytes at the tail.
  always_comb begin
    pop_n_p0    = pop ? pop_size : '0;
    tail_p0     = level - LEVEL_WIDTH'(pop_n_p0);
    kept_p0     = bytes_q >> {pop_n_p0, 3'b000};
    rx_bytes_p0 = BW'(push_data >> {push_offset, 3'b000});
    ins_mask_p0 = ~({BW{1'b1}} << {push_size, 3'b000});
    bytes_nxt   = kept_p0;
    level_nxt   = tail_p0;
    if (push) begin
      bytes_nxt = (kept_p0 & ~(ins_mask_p0 << {tail_p0, 3'b000}))
                | ((rx_bytes_p0 & ins_mask_p0) << {tail_p0, 3'b000});
      level_nxt = tail_p0 + LEVEL_WIDTH'(push_size);
    end
    head_nxt = bytes_nxt[DATA_WIDTH-1:0];
  end

  // Stage p1: byte store (contents beyond level are don't-care) and level.
  always_ff @(posedge clk) begin
    bytes_q <= bytes_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) level <= '0;
    else       level <= level_nxt;
  end

endmodule

// File: rtl/cfs_md_realigner.sv
// MD realigner: accepts RX beats of arbitrary legal offset/size, buffers the
// bytes, and re-emits them as TX beats of the configured offset/size.
//   pclk, reset                          : clock, sync active-high reset
//   md_rx_valid/data/offset/size         : RX beat
//   md_rx_ready, md_rx_err               : RX accept, illegal-beat flag
//   md_tx_valid/data/offset/size         : TX beat (registered)
//   md_tx_ready, md_tx_err               : TX accept, TX error response
//   ctrl_offset, ctrl_size               : requested TX alignment
//   stat_level                           : bytes buffered
//   stat_rx_drop, stat_tx_err            : saturating event counters
module cfs_md_realigner import cfs_md_pkg::*; #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int STAT_WIDTH   = 8,
  localparam int NB           = DATA_WIDTH / 8,
  localparam int OFFSET_WIDTH = offset_width(DATA_WIDTH),
  localparam int SIZE_WIDTH   = size_width(DATA_WIDTH),
  localparam int LEVEL_WIDTH  = level_width(DATA_WIDTH)
) (
  input  logic                    pclk,
  input  logic                    reset,
  input  logic                    md_rx_valid,
  input  logic [DATA_WIDTH-1:0]   md_rx_data,
  input  logic [OFFSET_WIDTH-1:0] md_rx_offset,
  input  logic [SIZE_WIDTH-1:0]   md_rx_size,
  output logic                    md_rx_ready,
  output logic                    md_rx_err,
  output logic                    md_tx_valid,
  output logic [DATA_WIDTH-1:0]   md_tx_data,
  output logic [OFFSET_WIDTH-1:0] md_tx_offset,
  output logic [SIZE_WIDTH-1:0]   md_tx_size,
  input  logic                    md_tx_ready,
  input  logic                    md_tx_err,
  input  logic [OFFSET_WIDTH-1:0] ctrl_offset,
  input  logic [SIZE_WIDTH-1:0]   ctrl_size,
  output logic [LEVEL_WIDTH-1:0]  stat_level,
  output logic [STAT_WIDTH-1:0]   stat_rx_drop,
  output logic [STAT_WIDTH-1:0]   stat_tx_err
);

  logic                    rx_fire_p0;
  logic                    rx_legal_p0;
  logic                    push_p0;
  logic                    pop_p0;
  logic                    ctrl_ok_p0;
  logic                    cfg_load_p0;
  logic [OFFSET_WIDTH-1:0] cfg_offset_q;
  logic [SIZE_WIDTH-1:0]   cfg_size_q;
  logic [OFFSET_WIDTH-1:0] cfg_offset_nxt;
  logic [SIZE_WIDTH-1:0]   cfg_size_nxt;
  logic [LEVEL_WIDTH-1:0]  level_q;
  logic [LEVEL_WIDTH-1:0]  level_nxt;
  logic [DATA_WIDTH-1:0]   head_nxt;
  logic [DATA_WIDTH-1:0]   tx_mask_p0;
  logic [DATA_WIDTH-1:0]   tx_data_nxt;

  // Stage p0: handshakes, legality and configuration selection.
  assign md_rx_ready = (level_q <= LEVEL_WIDTH'(NB));

  always_comb begin
    rx_legal_p0 = beat_legal(NB, int'(md_rx_offset), int'(md_rx_size));
    rx_fire_p0  = md_rx_valid && md_rx_ready && !reset;
    md_rx_err   = rx_fire_p0 && !rx_legal_p0;
    push_p0     = rx_fire_p0 && rx_legal_p0;
    pop_p0      = md_tx_valid && md_tx_ready;
    // An out-of-range request is ignored so the active size stays usable.
    ctrl_ok_p0  = (ctrl_size != '0) && (int'(ctrl_offset) + int'(ctrl_size) <= NB);
    cfg_load_p0 = (level_q == '0) && !push_p0 && ctrl_ok_p0;
    cfg_offset_nxt = cfg_load_p0 ? ctrl_offset : cfg_offset_q;
    cfg_size_nxt   = cfg_load_p0 ? ctrl_size   : cfg_size_q;
    tx_mask_p0  = ~({DATA_WIDTH{1'b1}} << {cfg_size_nxt, 3'b000});
    tx_data_nxt = (head_nxt & tx_mask_p0) << {cfg_offset_nxt, 3'b000};
  end

  cfs_md_byte_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buffer (
    .clk         (pclk),
    .reset       (reset),
    .pop         (pop_p0),
    .pop_size    (cfg_size_q),
    .push        (push_p0),
    .push_offset (md_rx_offset),
    .push_size   (md_rx_size),
    .push_data   (md_rx_data),
    .level       (level_q),
    .level_nxt   (level_nxt),
    .head_nxt    (head_nxt)
  );

  // Stage p1: active configuration, TX register and status counters.
  always_ff @(posedge pclk) begin
    if (reset) begin
      cfg_offset_q <= '0;
      cfg_size_q   <= SIZE_WIDTH'(NB);
    end else begin
      cfg_offset_q <= cfg_offset_nxt;
      cfg_size_q   <= cfg_size_nxt;
    end
  end

  // TX is computed from next-state so a beat accepted now is offered next
  // cycle; while stalled the head bytes cannot change, keeping TX stable.
  always_ff @(posedge pclk) begin
    if (reset) begin
      md_tx_valid <= 1'b0;
      md_tx_data  <= '0;
    end else begin
      md_tx_valid <= (level_nxt >= LEVEL_WIDTH'(cfg_size_nxt));
      md_tx_data  <= tx_data_nxt;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      stat_rx_drop <= '0;
      stat_tx_err  <= '0;
    end else begin
      if (md_rx_err)
        stat_rx_drop <= STAT_WIDTH'(sat_inc(32'(stat_rx_drop), STAT_WIDTH));
      if (pop_p0 && md_tx_err)
        stat_tx_err <= STAT_WIDTH'(sat_inc(32'(stat_tx_err), STAT_WIDTH));
    end
  end

  assign md_tx_offset = cfg_offset_q;
  assign md_tx_size   = cfg_size_q;
  assign stat_level   = level_q;

endmodule

// File: tb/tb_cfs_md_realigner.sv
// Bench for cfs_md_realigner with NB=4: directed scenarios with literal
// expectations, then randomized traffic compared against a byte-queue model.
module tb_cfs_md_realigner;

  localparam int NB = 4;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        md_rx_valid = 1'b0;
  logic [31:0] md_rx_data = '0;
  logic [1:0]  md_rx_offset = '0;
  logic [2:0]  md_rx_size = '0;
  logic        md_rx_ready;
  logic        md_rx_err;
  logic        md_tx_valid;
  logic [31:0] md_tx_data;
  logic [1:0]  md_tx_offset;
  logic [2:0]  md_tx_size;
  logic        md_tx_ready = 1'b0;
  logic        md_tx_err = 1'b0;
  logic [1:0]  ctrl_offset = '0;
  logic [2:0]  ctrl_size = 3'd4;
  logic [3:0]  stat_level;
  logic [7:0]  stat_rx_drop;
  logic [7:0]  stat_tx_err;

  always #5 pclk = ~pclk;

  cfs_md_realigner #(.DATA_WIDTH(32), .STAT_WIDTH(8)) dut (
    .pclk(pclk), .reset(reset),
    .md_rx_valid(md_rx_valid), .md_rx_data(md_rx_data),
    .md_rx_offset(md_rx_offset), .md_rx_size(md_rx_size),
    .md_rx_ready(md_rx_ready), .md_rx_err(md_rx_err),
    .md_tx_valid(md_tx_valid), .md_tx_data(md_tx_data),
    .md_tx_offset(md_tx_offset), .md_tx_size(md_tx_size),
    .md_tx_ready(md_tx_ready), .md_tx_err(md_tx_err),
    .ctrl_offset(ctrl_offset), .ctrl_size(ctrl_size),
    .stat_level(stat_level), .stat_rx_drop(stat_rx_drop), .stat_tx_err(stat_tx_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(int off, int sz);
    if (sz == 0 || off + sz > NB) return 1'b0;
    return ((NB + off) % sz) == 0;
  endfunction

  function automatic int sat8(int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // ---------------- behavioural model ----------------
  byte unsigned mq[$];
  int m_off = 0, m_size = NB, m_drop = 0, m_terr = 0;
  bit live = 1'b0;

  always @(posedge pclk) begin
    int  lvl;
    bit  fire, pop, app;
    if (reset) begin
      mq.delete();
      m_off = 0; m_size = NB; m_drop = 0; m_terr = 0;
      live = 1'b1;
    end else if (live) begin
      lvl  = mq.size();
      pop  = (lvl >= m_size) && md_tx_ready;
      fire = md_rx_valid && (lvl <= NB);
      app  = fire && legal(int'(md_rx_offset), int'(md_rx_size));
      if (pop) begin
        repeat (m_size) void'(mq.pop_front());
        if (md_tx_err) m_terr = sat8(m_terr);
      end
      if (fire && !app) m_drop = sat8(m_drop);
      if (app)
        for (int i = 0; i < int'(md_rx_size); i++)
          mq.push_back(md_rx_data[8*(int'(md_rx_offset)+i) +: 8]);
      if (lvl == 0 && !app) begin
        m_off  = int'(ctrl_offset);
        m_size = int'(ctrl_size);
      end
    end
  end

  always @(negedge pclk) begin
    int          lvl;
    bit          ev;
    logic [31:0] ed;
    if (live) begin
      lvl = mq.size();
      ev  = (lvl >= m_size);
      chk("level", 64'(stat_level), 64'(lvl));
      chk("rx_ready", 64'(md_rx_ready), 64'(lvl <= NB));
      chk("tx_valid", 64'(md_tx_valid), 64'(ev));
      chk("tx_offset", 64'(md_tx_offset), 64'(m_off));
      chk("tx_size", 64'(md_tx_size), 64'(m_size));
      chk("rx_drop_cnt", 64'(stat_rx_drop), 64'(m_drop));
      chk("tx_err_cnt", 64'(stat_tx_err), 64'(m_terr));
      chk("rx_err", 64'(md_rx_err),
          64'(!reset && md_rx_valid && (lvl <= NB) &&
              !legal(int'(md_rx_offset), int'(md_rx_size))));
      if (ev) begin
        ed = '0;
        for (int i = 0; i < m_size; i++)
          ed = ed | (32'(mq[i]) << (8 * (m_off + i)));
        chk("tx_data", 64'(md_tx_data), 64'(ed));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    md_rx_valid = 1'b0;
    md_tx_ready = 1'b0;
    md_tx_err   = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic send(input int off, input int sz, input logic [31:0] d);
    md_rx_valid  = 1'b1;
    md_rx_offset = 2'(off);
    md_rx_size   = 3'(sz);
    md_rx_data   = d;
    step();
    md_rx_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [31:0] held;
    step();
    step();

    // Split one full beat into two half beats.
    ctrl_offset = 2'd0; ctrl_size = 3'd2;
    do_reset();
    chk("rst_level", 64'(stat_level), 64'd0);
    chk("rst_tx_valid", 64'(md_tx_valid), 64'd0);
    step();
    chk("cfg_size2", 64'(md_tx_size), 64'd2);
    send(0, 4, 32'h4433_2211);
    chk("a_level", 64'(stat_level), 64'd4);
    chk("a_tx0", 64'(md_tx_data), 64'h0000_2211);
    md_tx_ready = 1'b1;
    step();
    chk("a_tx1", 64'(md_tx_data), 64'h0000_4433);
    chk("a_tx1_valid", 64'(md_tx_valid), 64'd1);
    step();
    chk("a_empty", 64'(md_tx_valid), 64'd0);
    md_tx_ready = 1'b0;

    // Gather three narrow beats into one full beat.
    ctrl_offset = 2'd0; ctrl_size = 3'd4;
    do_reset();
    step();
    send(1, 1, 32'h0000_AA00);
    send(2, 2, 32'hCCBB_0000);
    chk("b_partial_level", 64'(stat_level), 64'd3);
    chk("b_no_partial", 64'(md_tx_valid), 64'd0);
    send(3, 1, 32'hDD00_0000);
    chk("b_tx", 64'(md_tx_data), 64'hDDCC_BBAA);
    chk("b_tx_valid", 64'(md_tx_valid), 64'd1);
    md_tx_ready = 1'b1;
    step();
    chk("b_drained", 64'(stat_level), 64'd0);
    md_tx_ready = 1'b0;

    // Illegal beats are flagged and dropped.
    do_reset();
    step();
    md_rx_valid = 1'b1; md_rx_offset = 2'd3; md_rx_size = 3'd2; md_rx_data = 32'h1234_5678;
    #1 chk("c_err_oob", 64'(md_rx_err), 64'd1);
    step();
    chk("c_drop1", 64'(stat_rx_drop), 64'd1);
    md_rx_offset = 2'd0; md_rx_size = 3'd0;
    #1 chk("c_err_size0", 64'(md_rx_err), 64'd1);
    step();
    chk("c_drop2", 64'(stat_rx_drop), 64'd2);
    md_rx_offset = 2'd1; md_rx_size = 3'd2;
    #1 chk("c_err_misaligned", 64'(md_rx_err), 64'd1);
    step();
    chk("c_drop3", 64'(stat_rx_drop), 64'd3);
    md_rx_valid = 1'b0;
    #1 chk("c_err_idle", 64'(md_rx_err), 64'd0);
    chk("c_no_tx", 64'(md_tx_valid), 64'd0);
    chk("c_level", 64'(stat_level), 64'd0);

    // Backpressure up to L=5, then simultaneous pop and push.
    ctrl_offset = 2'd0; ctrl_size = 3'd2;
    do_reset();
    step();
    send(0, 4, 32'h4433_2211);
    send(3, 1, 32'h5500_0000);
    chk("d_level5", 64'(stat_level), 64'd5);
    chk("d_rx_blocked", 64'(md_rx_ready), 64'd0);
    held = md_tx_data;
    chk("d_tx_head", 64'(held), 64'h0000_2211);
    md_rx_valid = 1'b1; md_rx_offset = 2'd0; md_rx_size = 3'd4; md_rx_data = 32'h9988_7766;
    step();
    step();
    chk("d_stable", 64'(md_tx_data), 64'(held));
    chk("d_still5", 64'(stat_level), 64'd5);
    md_tx_ready = 1'b1;
    step();
    chk("d_pop_only", 64'(stat_level), 64'd3);
    chk("d_tx_next", 64'(md_tx_data), 64'h0000_4433);
    step();
    chk("d_pop_push", 64'(stat_level), 64'd5);
    chk("d_tx_merge", 64'(md_tx_data), 64'h0000_6655);
    md_rx_valid = 1'b0; md_tx_ready = 1'b0;

    // TX error responses and counter saturation.
    ctrl_offset = 2'd0; ctrl_size = 3'd4;
    do_reset();
    step();
    md_tx_ready = 1'b1; md_tx_err = 1'b1;
    for (int i = 0; i < 300; i++) begin
      md_rx_valid = 1'b1; md_rx_offset = 2'd0; md_rx_size = 3'd4; md_rx_data = $urandom;
      step();
      if (i == 1) chk("e_first_err", 64'(stat_tx_err), 64'd1);
    end
    md_rx_valid = 1'b0;
    step();
    chk("e_saturated", 64'(stat_tx_err), 64'd255);
    chk("e_consumed", 64'(stat_level), 64'd0);
    md_tx_ready = 1'b0; md_tx_err = 1'b0;

    // Reset with bytes buffered.
    do_reset();
    step();
    send(0, 2, 32'h0000_BEEF);
    send(0, 1, 32'h0000_0042);
    chk("f_level3", 64'(stat_level), 64'd3);
    ctrl_offset = 2'd2; ctrl_size = 3'd2;
    reset = 1'b1;
    step();
    chk("f_level0", 64'(stat_level), 64'd0);
    chk("f_tx_valid", 64'(md_tx_valid), 64'd0);
    chk("f_tx_data", 64'(md_tx_data), 64'd0);
    chk("f_rx_ready", 64'(md_rx_ready), 64'd1);
    chk("f_cfg_off", 64'(md_tx_offset), 64'd0);
    chk("f_cfg_size", 64'(md_tx_size), 64'd4);
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      r = int'($urandom_range(0, 6));
      if ($urandom_range(0, 3) != 0) begin
        case (r)
          0: begin md_rx_offset = 2'd0; md_rx_size = 3'd1; end
          1: begin md_rx_offset = 2'd1; md_rx_size = 3'd1; end
          2: begin md_rx_offset = 2'd2; md_rx_size = 3'd1; end
          3: begin md_rx_offset = 2'd3; md_rx_size = 3'd1; end
          4: begin md_rx_offset = 2'd0; md_rx_size = 3'd2; end
          5: begin md_rx_offset = 2'd2; md_rx_size = 3'd2; end
          default: begin md_rx_offset = 2'd0; md_rx_size = 3'd4; end
        endcase
      end else begin
        md_rx_offset = 2'($urandom_range(0, 3));
        md_rx_size   = 3'($urandom_range(0, 7));
      end
      md_rx_data  = $urandom;
      md_rx_valid = ($urandom_range(0, 9) < 7);
      md_tx_ready = ($urandom_range(0, 9) < 6);
      md_tx_err   = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 19) == 0) begin
        r = int'($urandom_range(1, 4));
        ctrl_size   = 3'(r);
        ctrl_offset = 2'($urandom_range(0, NB - r));
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    md_rx_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
